// File: rtl/ps2_host_tx_if.sv
// Command/status and PS/2 pad signals of the host-to-device PS/2 transmitter.
// master = requester plus pad model, slave = ps2_host_tx.
interface ps2_host_tx_if;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       PS2_CLK_in;
   logic       PS2_DAT_in;
   logic       ps2_clk_drive_low;
   logic       ps2_dat_drive_low;
   logic       busy;
   logic       done;
   logic       ack_ok;
   logic       error;

   modport master (
      output tx_data, tx_start, PS2_CLK_in, PS2_DAT_in,
      input  ps2_clk_drive_low, ps2_dat_drive_low, busy, done, ack_ok, error
   );

   modport slave (
      input  tx_data, tx_start, PS2_CLK_in, PS2_DAT_in,
      output ps2_clk_drive_low, ps2_dat_drive_low, busy, done, ack_ok, error
   );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, 11-bit frame, ACK, timeout.
// Optional macro PS2_TX_RETRY_EN: one automatic resend of the latched byte after a NACK or timeout.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 750000,
   parameter int SYNC_STAGES    = 2
) (
   input logic          CLOCK_50,
   input logic          reset,
   ps2_host_tx_if.slave bus
);
   localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_INHIBIT, S_RTS, S_SEND, S_ACK, S_WAIT_IDLE
   } state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
   logic                   clk_prev;
   logic [CNT_W-1:0]       cnt;
   logic [3:0]             bit_idx;
   logic [7:0]             tx_byte;
   logic                   nack;
   logic                   clk_drive_low, dat_drive_low, busy_r, done_r, ack_ok_r, error_r;
`ifdef PS2_TX_RETRY_EN
   logic                   retried;
`endif

   logic       clk_s, dat_s, fe, fe_live, timed, timeout_hit, fail;
   logic [9:0] frame;

   assign clk_s   = clk_sync[SYNC_STAGES-1];
   assign dat_s   = dat_sync[SYNC_STAGES-1];
   assign fe      = clk_prev & ~clk_s;
   assign fe_live = fe && (state == S_SEND || state == S_ACK);
   assign timed   = state inside {S_RTS, S_SEND, S_ACK, S_WAIT_IDLE};
   // A falling edge in the same cycle as the last count restarts the window instead of aborting.
   assign timeout_hit = timed && !fe_live && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
   assign fail        = timeout_hit || (state == S_WAIT_IDLE && clk_s && dat_s && nack);
   // Bit 9 is the stop bit, sent by releasing DAT.
   assign frame       = {1'b1, ~^tx_byte, tx_byte};

   assign bus.ps2_clk_drive_low = clk_drive_low;
   assign bus.ps2_dat_drive_low = dat_drive_low;
   assign bus.busy              = busy_r;
   assign bus.done              = done_r;
   assign bus.ack_ok            = ack_ok_r;
   assign bus.error             = error_r;

   // NOTE: synchronizers reset to the idle-high line level so no false falling edge follows reset.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         clk_sync <= '1;
         dat_sync <= '1;
         clk_prev <= 1'b1;
      end else begin
         clk_sync <= {clk_sync[SYNC_STAGES-2:0], bus.PS2_CLK_in};
         dat_sync <= {dat_sync[SYNC_STAGES-2:0], bus.PS2_DAT_in};
         clk_prev <= clk_s;
      end
   end

   // NOTE: all state updates use non-blocking assignments so every branch sees pre-edge values.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state         <= S_IDLE;
         cnt           <= '0;
         bit_idx       <= '0;
         tx_byte       <= '0;
         nack          <= 1'b0;
         clk_drive_low <= 1'b0;
         dat_drive_low <= 1'b0;
         busy_r        <= 1'b0;
         done_r        <= 1'b0;
         ack_ok_r      <= 1'b0;
         error_r       <= 1'b0;
`ifdef PS2_TX_RETRY_EN
         retried       <= 1'b0;
`endif
      end else begin
         done_r <= 1'b0;
         if (fail) begin
`ifdef PS2_TX_RETRY_EN
            if (!retried) begin
               retried       <= 1'b1;
               state         <= S_INHIBIT;
               cnt           <= '0;
               nack          <= 1'b0;
               clk_drive_low <= 1'b1;
               dat_drive_low <= 1'b0;
            end else
`endif
            begin
               state         <= S_IDLE;
               clk_drive_low <= 1'b0;
               dat_drive_low <= 1'b0;
               busy_r        <= 1'b0;
               done_r        <= 1'b1;
               ack_ok_r      <= 1'b0;
               error_r       <= 1'b1;
            end
         end else begin
            case (state)
               S_IDLE: begin
                  if (bus.tx_start) begin
                     tx_byte       <= bus.tx_data;
                     busy_r        <= 1'b1;
                     ack_ok_r      <= 1'b0;
                     error_r       <= 1'b0;
                     cnt           <= '0;
                     nack          <= 1'b0;
                     clk_drive_low <= 1'b1;
                     state         <= S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
                     retried       <= 1'b0;
`endif
                  end
               end
               S_INHIBIT: begin
                  if (cnt == CNT_W'(INHIBIT_CYCLES - 1)) begin
                     clk_drive_low <= 1'b0;
                     dat_drive_low <= 1'b1;
                     cnt           <= '0;
                     state         <= S_RTS;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               S_RTS: begin
                  if (clk_s) begin
                     bit_idx <= '0;
                     cnt     <= '0;
                     state   <= S_SEND;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               S_SEND: begin
                  if (fe) begin
                     dat_drive_low <= ~frame[bit_idx];
                     bit_idx       <= bit_idx + 1'b1;
                     cnt           <= '0;
                     if (bit_idx == 4'd9) state <= S_ACK;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               S_ACK: begin
                  if (fe) begin
                     nack  <= dat_s;
                     cnt   <= '0;
                     state <= S_WAIT_IDLE;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               S_WAIT_IDLE: begin
                  // A NACK leaves through the fail path once the lines go idle.
                  if (clk_s && dat_s) begin
                     state    <= S_IDLE;
                     busy_r   <= 1'b0;
                     done_r   <= 1'b1;
                     ack_ok_r <= 1'b1;
                     error_r  <= 1'b0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter. It sends one command byte to the keyboard, for example 0xED (set LEDs) or 0xFF (reset). It sits beside the keyboard receive block on the same PS2_CLK/PS2_DAT pair and drives both lines open-drain. It runs the full host-request sequence (inhibit, request-to-send, 8 data bits plus odd parity plus stop, device ACK) from the system clock, with a timeout.

Parameters:
INHIBIT_CYCLES, 5000, CLOCK_50 cycles PS2_CLK is held low before the request (100 us at 50 MHz).
TIMEOUT_CYCLES, 750000, maximum CLOCK_50 cycles between consecutive device clock events before abort (15 ms).
SYNC_STAGES, 2, flip-flop stages on PS2_CLK_in and PS2_DAT_in (must be at least 2).

Ports:
CLOCK_50  input  1  system clock; all state is on its rising edge.
reset  input  1  asynchronous, active-high reset.
tx_data  input  8  byte to send; captured when tx_start is accepted.
tx_start  input  1  single-cycle request; accepted only when busy=0.
PS2_CLK_in  input  1  raw PS2_CLK pad level.
PS2_DAT_in  input  1  raw PS2_DAT pad level.
ps2_clk_drive_low  output  1  1 = pull PS2_CLK low; 0 = release (pad tristated).
ps2_dat_drive_low  output  1  1 = pull PS2_DAT low; 0 = release.
busy  output  1  high from accept until done.
done  output  1  one-cycle pulse at end of every transaction (success or failure).
ack_ok  output  1  valid with done: 1 = device ACKed (DAT sampled low).
error  output  1  valid with done: 1 = timeout or NACK; held until next accept.

Behaviour:
- Reset (asynchronous): state IDLE; both drive_low outputs 0 (lines released at once, even mid-frame); busy, done, ack_ok and error all 0; counters 0.
- Synchronizers: PS2_CLK_in and PS2_DAT_in each pass through SYNC_STAGES flops. The falling-edge strobe fe is prev_sync=1 and cur_sync=0, and is honoured only in SEND and ACK.
- Frame: {odd parity, tx_data} is latched on accept. Parity = ~^tx_data (0xED gives 1; 0x07 gives 0).
- IDLE: on tx_start=1, capture the byte, set busy=1, go to INHIBIT. tx_start while busy is ignored and not queued.
- INHIBIT: clk_drive_low=1 for exactly INHIBIT_CYCLES cycles. In the last cycle, set dat_drive_low=1 (start bit), then go to RTS.
- RTS: clk_drive_low=0 and dat stays low. Wait for synced CLK=1, then go to SEND with bit index 0 and the timeout counter cleared.
- SEND: on each fe, drive the next bit (dat_drive_low = ~bit):
  - fe 1 to 8: data bits LSB first.
  - fe 9: parity.
  - fe 10: release DAT (stop bit = 1), then go to ACK.
- ACK: on fe 11, sample synced DAT. Low sets ack_ok=1; high sets error=1. Go to WAIT_IDLE.
- WAIT_IDLE: wait for synced CLK=1 and DAT=1, then pulse done, clear busy and return to IDLE. A NACK ends here with done, error=1, ack_ok=0.
- Timeout: in RTS, SEND, ACK and WAIT_IDLE, the counter increments each cycle and clears on every fe. When it reaches TIMEOUT_CYCLES:
  - release both lines;
  - set error=1 and ack_ok=0;
  - pulse done, clear busy, go to IDLE.
- Latency: done occurs no earlier than INHIBIT_CYCLES + SYNC_STAGES + 11 device clock periods after accept.
- The receive block sees this traffic too. Suppressing that is out of scope here.

Optional Feature:
Macro PS2_TX_RETRY_EN.
- Defined: on the first NACK or timeout, the block re-enters INHIBIT with the same latched byte instead of finishing. busy stays high and no done is pulsed. A second failure finishes with error=1. The retry count resets on each accept.
- Undefined: the first failure finishes immediately, as described above.

Test Plan:
- tx_data=0xED, device model clocks at 12 kHz and ACKs: after fe 1..10, sampled DAT = 1,0,1,1,0,1,1,1, parity 1, stop 1. Then done=1, ack_ok=1, error=0.
- tx_data=0x07 with ACK: parity bit sampled 0; CLK held low exactly INHIBIT_CYCLES=5000 cycles before release; start bit low when CLK releases.
- Device leaves DAT high at fe 11: done pulses with ack_ok=0, error=1, lines released. With PS2_TX_RETRY_EN, a second inhibit phase runs before done.
- Device never clocks after RTS: done with error=1 exactly TIMEOUT_CYCLES cycles after CLK is seen high; both drive_low outputs 0.
- Assert reset during SEND at fe 5: both drive_low outputs drop to 0 without waiting for a clock edge, busy=0. The next tx_start=0x FF sends a complete frame with ACK.
- tx_start pulsed with 0x00 while busy with 0xED: ignored; the frame on the wire stays 0xED and exactly one done pulse occurs.
